fp_muldiv_iter: RTL
===================

// Module: fp_muldiv_iter
// PURPOSE
//  Multi-cycle IEEE-754 binary32 multiply/divide unit. It responds to the stimulus side of the mul/div
//  interface (a, b, sel, en) and returns R plus the five exception flags. It adds a start/busy/done
//  handshake, so one shared iterative mantissa datapath replaces a combinational array.
//  Round-to-nearest-even only. Subnormal inputs are treated as zero (DAZ). Tiny results flush to zero.
// PARAMETERS
//  MUL_ITERS  24  shift-add iterations for the multiply mantissa (24x24 product)
//  DIV_ITERS  26  restoring-division iterations (24 quotient bits + guard + round; remainder -> sticky)
// PORTS
//  clk      in   1   single clock, rising edge
//  arst     in   1   asynchronous reset, active-high
//  en       in   1   global enable; 0 = freeze FSM, counters and outputs
//  start    in   1   request; sampled only in IDLE with en=1
//  sel      in   1   0 = a*b, 1 = a/b (captured with start)
//  a        in   32  operand A, binary32 (captured with start)
//  b        in   32  operand B, binary32 (captured with start)
//  busy     out  1   high from the accept edge until DONE is left
//  done     out  1   single-cycle pulse; R and flags are valid from this cycle
//  R        out  32  result, held until the next accepted start
//  io_flag  out  1   invalid operation
//  dz_flag  out  1   divide by zero
//  of_flag  out  1   overflow
//  uf_flag  out  1   underflow
//  i_flag   out  1   inexact
// BEHAVIOUR
//  Reset: arst=1 forces state=IDLE; busy, done, R and all flags go to 0; counter=0; captured operands cleared.
//  FSM states and transitions:
//   IDLE  : start & en -> capture a, b, sel; go to CHECK.
//   CHECK : classify operands.
//           special -> load R/flags, go to DONE.
//           else -> go to ITER with cnt=0, exp = ea+eb-127 (mul) or ea-eb+127 (div), 10-bit signed.
//   ITER  : one mantissa step per cycle. Leave at cnt = MUL_ITERS-1 or DIV_ITERS-1 -> NORM.
//   NORM  : mul 48b product: shift 1 if bit47 set (exp+1). div: shift 1 if quotient MSB clear (exp-1).
//           Form guard, round and sticky bits.
//   ROUND : RNE increment; a mantissa carry-out bumps exp.
//           exp>=255 -> +-INF, of=1, i=1.
//           exp<=0 -> +-0, uf=1, i=1.
//           else pack; i = G|R|S. Go to DONE.
//   DONE  : done=1 for one cycle, then IDLE. start is ignored in DONE.
//  Latency (accept edge to done cycle):
//   special operands = 2 cycles
//   mul = MUL_ITERS+4 = 28 cycles
//   div = DIV_ITERS+4 = 30 cycles
//  Sign of every non-NaN result = a[31]^b[31].
//  Special cases (resolved in CHECK):
//   NaN operand, 0*INF, INF*0, 0/0, INF/INF -> R=0x7FC00000, io=1.
//   finite-nonzero/0 -> +-INF, dz=1.
//   INF*x, INF/finite -> +-INF, no flags.
//   0*finite, 0/nonzero, finite/INF -> +-0, no flags.
//   x*1.0 and x/1.0 take the normal path; no shortcut.
//  Flags are cleared on every accepted start; flags never accumulate.
//  en=0 in any state: all registers hold. A done pulse that is pending stays pending until en returns.
//  start while busy: ignored, no effect on the captured operands.
//  arst mid-operation: result is discarded immediately. No done pulse. R returns to 0.
// STRUCTURE
//  Package fp_pkg:
//   - constants INF=0x7F800000, ZERO=0x00000000, ONE=0x3F800000, QNAN=0x7FC00000, BIAS=127
//   - typedef struct packed {sign; exp[7:0]; man[22:0]} fp32_t
//   - typedef enum {IDLE, CHECK, ITER, NORM, ROUND, DONE} state_t
//   - typedef struct packed {is_zero, is_inf, is_nan} fp_class_t
//  Sub-module fp32_classify: combinational, fp32_t -> fp_class_t. Instantiated twice, for a and b.
//  All other logic lives in this module.
// TESTING
//  Check every scenario against the $shortrealtobits reference model; flags compared bit-exact.
//  T1 mul: sel=0, a=0x40400000 (3.0), b=0x40000000 (2.0)
//      -> R=0x40C00000, all flags 0, done exactly 28 cycles after accept.
//  T2 div: sel=1, a=0x3F800000, b=0x40400000
//      -> R=0x3EAAAAAB, i=1, done at 30 cycles.
//  T3 specials:
//      1.0/0 -> R=0x7F800000, dz=1
//      0*INF -> R=0x7FC00000, io=1
//      both at 2-cycle latency.
//  T4 range:
//      0x7F7FFFFF*0x40000000 -> R=0x7F800000, of=1, i=1
//      0x00800000/0x40000000 -> R=0x00000000, uf=1, i=1
//  T5 control:
//      arst pulse at iteration 10 -> no done pulse, R=0
//      en=0 for 5 cycles mid-ITER -> done delayed by exactly 5 cycles
//      start while busy -> ignored
//  T6 random: 10k random normal a, b, random sel, back-to-back starts
//      -> R and flags match the model.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared binary32 constants and types for the iterative multiply/divide unit.
package fp_pkg;
    localparam logic [31:0] INF  = 32'h7F80_0000;
    localparam logic [31:0] ZERO = 32'h0000_0000;
    localparam logic [31:0] ONE  = 32'h3F80_0000;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam int          BIAS = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef enum logic [2:0] {IDLE, CHECK, ITER, NORM, ROUND, DONE} state_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
    } fp_class_t;

    typedef struct packed {
        logic io;
        logic dz;
        logic of;
        logic uf;
        logic ix;
    } fp_flags_t;
endpackage

// File: rtl/fp32_classify.sv
// Operand classifier: zero (subnormals count as zero), infinity, NaN.
// Purely combinational, no latency, no flow control.
module fp32_classify
    import fp_pkg::*;
(
    input  fp32_t     op,
    output fp_class_t cls
);
    always_comb begin
        cls.is_zero = (op.exp == 8'h00);
        cls.is_inf  = (op.exp == 8'hFF) && (op.man == 23'd0);
        cls.is_nan  = (op.exp == 8'hFF) && (op.man != 23'd0);
    end
endmodule

// File: rtl/fp_muldiv_iter.sv
// Iterative binary32 mul/div, RNE, DAZ/FTZ; latency 2 (special), MUL_ITERS+4, DIV_ITERS+4.
// start/busy/done handshake: start accepted only when idle; en=0 freezes every register.
module fp_muldiv_iter
    import fp_pkg::*;
#(
    parameter int MUL_ITERS = 24,
    parameter int DIV_ITERS = 26
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        en,
    input  logic        start,
    input  logic        sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] R,
    output logic        io_flag,
    output logic        dz_flag,
    output logic        of_flag,
    output logic        uf_flag,
    output logic        i_flag
);
    localparam logic [4:0]        MUL_LAST = 5'(MUL_ITERS - 1);
    localparam logic [4:0]        DIV_LAST = 5'(DIV_ITERS - 1);
    localparam logic signed [9:0] BIAS_S   = 10'(BIAS);

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    fp32_t             a_q, a_d, b_q, b_d;
    logic              sel_q, sel_d, sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [47:0]       acc_q, acc_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       man_q, man_d;
    logic [2:0]        grs_q, grs_d;
    logic [31:0]       r_q, r_d;
    fp_flags_t         flags_q, flags_d;

    fp_class_t         cls_a, cls_b;
    logic [23:0]       ma, mb;
    logic signed [9:0] ea, eb, exp_r;
    logic [24:0]       mul_sum, rnd_sum;
    logic [25:0]       div_diff;
    logic              rnd_inc, sgn;

    fp32_classify u_cls_a (.op(a_q), .cls(cls_a));
    fp32_classify u_cls_b (.op(b_q), .cls(cls_b));

    assign ma       = {1'b1, a_q.man};
    assign mb       = {1'b1, b_q.man};
    assign ea       = $signed({2'b00, a_q.exp});
    assign eb       = $signed({2'b00, b_q.exp});
    assign sgn      = a_q.sign ^ b_q.sign;
    // Multiplier sits in acc[23:0] and is consumed LSB-first while the partial product shifts in.
    assign mul_sum  = {1'b0, acc_q[47:24]} + (acc_q[0] ? {1'b0, ma} : 25'd0);
    assign div_diff = {1'b0, rem_q} - {2'b00, mb};
    assign rnd_inc  = grs_q[2] & (grs_q[1] | grs_q[0] | man_q[0]);
    assign rnd_sum  = {1'b0, man_q} + {24'd0, rnd_inc};
    assign exp_r    = exp_q + (rnd_sum[24] ? 10'sd1 : 10'sd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        man_d   = man_q;
        grs_d   = grs_q;
        r_d     = r_q;
        flags_d = flags_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sel_d   = sel;
                    flags_d = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                sign_d  = sgn;
                cnt_d   = '0;
                acc_d   = sel_q ? 48'd0 : {24'd0, mb};
                rem_d   = {1'b0, ma};
                exp_d   = sel_q ? (ea - eb + BIAS_S) : (ea + eb - BIAS_S);
                state_d = DONE;
                if (cls_a.is_nan || cls_b.is_nan) begin
                    r_d        = QNAN;
                    flags_d.io = 1'b1;
                end else if (!sel_q) begin
                    if ((cls_a.is_zero && cls_b.is_inf) || (cls_a.is_inf && cls_b.is_zero)) begin
                        r_d        = QNAN;
                        flags_d.io = 1'b1;
                    end else if (cls_a.is_inf || cls_b.is_inf) begin
                        r_d = {sgn, INF[30:0]};
                    end else if (cls_a.is_zero || cls_b.is_zero) begin
                        r_d = {sgn, ZERO[30:0]};
                    end else begin
                        state_d = ITER;
                    end
                end else begin
                    if ((cls_a.is_zero && cls_b.is_zero) || (cls_a.is_inf && cls_b.is_inf)) begin
                        r_d        = QNAN;
                        flags_d.io = 1'b1;
                    end else if (cls_a.is_inf) begin
                        r_d = {sgn, INF[30:0]};
                    end else if (cls_b.is_zero) begin
                        r_d        = {sgn, INF[30:0]};
                        flags_d.dz = 1'b1;
                    end else if (cls_a.is_zero || cls_b.is_inf) begin
                        r_d = {sgn, ZERO[30:0]};
                    end else begin
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q + 5'd1;
                if (!sel_q) begin
                    acc_d = {mul_sum, acc_q[23:1]};
                end else begin
                    // Restoring step: quotient bits enter at acc[0], first bit has weight 2^0.
                    acc_d = {acc_q[46:0], ~div_diff[25]};
                    rem_d = div_diff[25] ? {rem_q[23:0], 1'b0} : {div_diff[23:0], 1'b0};
                end
                if (cnt_q == (sel_q ? DIV_LAST : MUL_LAST)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                state_d = ROUND;
                if (!sel_q) begin
                    if (acc_q[47]) begin
                        man_d = acc_q[47:24];
                        grs_d = {acc_q[23], acc_q[22], |acc_q[21:0]};
                        exp_d = exp_q + 10'sd1;
                    end else begin
                        man_d = acc_q[46:23];
                        grs_d = {acc_q[22], acc_q[21], |acc_q[20:0]};
                    end
                end else begin
                    if (acc_q[25]) begin
                        man_d = acc_q[25:2];
                        grs_d = {acc_q[1], acc_q[0], |rem_q};
                    end else begin
                        man_d = acc_q[24:1];
                        grs_d = {acc_q[0], 1'b0, |rem_q};
                        exp_d = exp_q - 10'sd1;
                    end
                end
            end
            ROUND: begin
                state_d = DONE;
                exp_d   = exp_r;
                if (exp_r >= 10'sd255) begin
                    r_d        = {sign_q, INF[30:0]};
                    flags_d.of = 1'b1;
                    flags_d.ix = 1'b1;
                end else if (exp_r <= 10'sd0) begin
                    r_d        = {sign_q, ZERO[30:0]};
                    flags_d.uf = 1'b1;
                    flags_d.ix = 1'b1;
                end else begin
                    // On a rounding carry the fraction field is all zeros either way.
                    r_d        = {sign_q, exp_r[7:0], rnd_sum[22:0]};
                    flags_d.ix = |grs_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            man_q   <= '0;
            grs_q   <= '0;
            r_q     <= '0;
            flags_q <= '0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            man_q   <= man_d;
            grs_q   <= grs_d;
            r_q     <= r_d;
            flags_q <= flags_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign R       = r_q;
    assign io_flag = flags_q.io;
    assign dz_flag = flags_q.dz;
    assign of_flag = flags_q.of;
    assign uf_flag = flags_q.uf;
    assign i_flag  = flags_q.ix;
endmodule
